dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmemory32) between two requesters: the CPU data path (MemOrIO side) and the UART program/data loader write port.
- Sits between MemOrIO/loader and dmemory32.
- Sequences every access through a 3-state FSM with a req/ack handshake.
- Drives a cpu_stall that gates the CPU clock enable while a CPU access is pending.
- Gives the loader priority, with a starvation bound for the CPU, and lets boot_mode lock the CPU out during program load.

Parameters:
ADDR_W, 14, word-address width of dmemory32
DATA_W, 32, data width
MAX_HOLD, 3, max consecutive contended loader grants before the CPU must be granted (range 1..15)

Ports:
clock  in  1  system clock (cpuclk output); all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
boot_mode  in  1  1 = loader-only mode; CPU requests not granted
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data
cpu_stall  out  1  cpu_req & ~cpu_ack
ld_req  in  1  loader write request, level, held until ld_ack
ld_addr  in  ADDR_W  loader word address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  one-cycle completion pulse
mem_we  out  1  to dmemory32 write enable
mem_addr  out  ADDR_W  to dmemory32 address
mem_wdata  out  DATA_W  to dmemory32 write data
mem_rdata  in  DATA_W  from dmemory32; synchronous read, valid the cycle after the address edge
owner  out  1  0 = CPU, 1 = loader; the requester of the current or last access

Behaviour:
Reset:
- reset=0 forces state IDLE asynchronously.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, owner=0, hold_cnt=0, rdata_q=0, cpu_ack=0, ld_ack=0.
- cpu_stall follows cpu_req (combinational).

States: IDLE, ISSUE, RESP. Each access is exactly IDLE -> ISSUE -> RESP -> IDLE, one state per cycle. No back-to-back skipping of IDLE.

IDLE:
- Eligibility: eC = cpu_req & ~boot_mode; eL = ld_req.
- Winner selection:
  - eL & ~eC: loader.
  - eC & ~eL: CPU.
  - Both: loader, unless hold_cnt == MAX_HOLD, then CPU.
- On a grant, at the clock edge:
  - Register mem_addr, mem_wdata, owner.
  - mem_we = cpu_we for the CPU, 1 for the loader.
  - state -> ISSUE.
- hold_cnt update:
  - Loader grant with eC=1: hold_cnt+1, saturating at MAX_HOLD.
  - Loader grant with eC=0: 0.
  - CPU grant: 0.
- No eligible request: stay in IDLE; mem_we=0; mem_addr and mem_wdata hold.

ISSUE:
- mem_* are stable; the memory commits the write / samples the read address at the end-of-cycle edge.
- At the edge: mem_we -> 0, state -> RESP.

RESP:
- Assert ack for owner only (cpu_ack or ld_ack = 1 for this cycle).
- CPU read: cpu_rdata = mem_rdata (combinational) during RESP; rdata_q <= mem_rdata at the edge.
- Outside a CPU-read RESP: cpu_rdata = rdata_q. Writes do not update rdata_q.
- state -> IDLE.

Latency:
- Request seen in IDLE at cycle n -> ack in cycle n+2.
- Next grant is possible at the edge ending cycle n+3.
- A requester keeping req high after its ack is treated as a new request.
- Requesters must keep addr/we/wdata stable from req rise through ack. Changes are sampled only at the grant edge.

Boundary conditions:
- boot_mode is sampled only in IDLE. An in-flight CPU access completes normally if boot_mode rises mid-access.
- A req dropping before its ack is a protocol violation. The already-granted access still completes and acks.
- Reset during ISSUE of a write: mem_we drops asynchronously, so no write is committed. No ack is issued.
- Addresses pass through unmodified. No wrap or range checking (MemOrIO filters I/O addresses).

Test Plan:
1. Reset check: hold reset=0 with cpu_req=1 -> mem_we=0, mem_addr=0, cpu_ack=0, ld_ack=0, cpu_stall=1, owner=0; release -> first grant on the next IDLE edge.
2. CPU read: preload mem[0x010]=0xDEADBEEF; cpu_req=1, cpu_we=0, cpu_addr=0x010 at cycle 0 -> mem_addr=0x010 in cycle 1; cpu_ack=1 and cpu_rdata=0xDEADBEEF in cycle 2; cpu_stall=1 in cycles 0-1, 0 in cycle 2; cpu_rdata stays 0xDEADBEEF afterwards.
3. Loader write then CPU readback: ld write 0x12345678 to 0x3FF (boot_mode=1) -> ld_ack in cycle 2; then boot_mode=0, CPU read of 0x3FF -> cpu_rdata=0x12345678.
4. Contention, MAX_HOLD=3: cpu_req and ld_req held high, each re-requesting after its ack -> grant order L,L,L,C,L,L,L,C; hold_cnt returns to 0 after each C.
5. Boot lock: boot_mode=1, cpu_req=1, ld_req idle for 20 cycles -> no cpu_ack, cpu_stall=1 throughout; drop boot_mode -> cpu_ack exactly 2 cycles after the next IDLE.
6. Reset mid-write: CPU write of 0xAAAA5555 to 0x020 (old value 0x0); assert reset during ISSUE -> mem_we=0 immediately, mem[0x020] still 0x0, no cpu_ack, state IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbiter sharing single-port dmemory32 between the CPU data path and the UART loader.
// Each access walks IDLE -> ISSUE -> RESP; loader has priority with a bounded CPU starvation window.
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              boot_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              op_we_q, op_we_d;
    logic [3:0]        hold_q, hold_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              e_cpu, e_ld;

    assign e_cpu = cpu_req & ~boot_mode;
    assign e_ld  = ld_req;

    always_comb begin
        state_d  = state_q;
        mem_we_d = mem_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        op_we_d  = op_we_q;
        hold_d   = hold_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                mem_we_d = 1'b0;
                if (e_ld && (!e_cpu || hold_q != HOLD_MAX)) begin
                    state_d  = ISSUE;
                    mem_we_d = 1'b1;
                    addr_d   = ld_addr;
                    wdata_d  = ld_wdata;
                    owner_d  = 1'b1;
                    op_we_d  = 1'b1;
                    // Only contended loader wins count toward the CPU starvation bound.
                    if (!e_cpu)
                        hold_d = 4'd0;
                    else if (hold_q != HOLD_MAX)
                        hold_d = hold_q + 4'd1;
                end else if (e_cpu) begin
                    state_d  = ISSUE;
                    mem_we_d = cpu_we;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    owner_d  = 1'b0;
                    op_we_d  = cpu_we;
                    hold_d   = 4'd0;
                end
            end
            ISSUE: begin
                mem_we_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (!owner_q && !op_we_q)
                    rdata_d = mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
            op_we_q  <= 1'b0;
            hold_q   <= 4'd0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            op_we_q  <= op_we_d;
            hold_q   <= hold_d;
            rdata_q  <= rdata_d;
        end
    end

    // Read data is forwarded straight from memory in RESP so the CPU sees it with its ack.
    assign cpu_ack   = (state_q == RESP) && !owner_q;
    assign ld_ack    = (state_q == RESP) && owner_q;
    assign cpu_rdata = (cpu_ack && !op_we_q) ? mem_rdata : rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-read memory and a result scoreboard.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        boot_mode = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ld_req = 1'b0;
    logic [13:0] ld_addr = '0;
    logic [31:0] ld_wdata = '0;
    logic        ld_ack;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        owner;

    dmem_arbiter dut (
        .clock(clock), .reset(reset), .boot_mode(boot_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:16383];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] own_q [$];
    int n;
    int got;
    int cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cpu_ack(output int cycles);
        cycles = 0;
        while (!cpu_ack && cycles < 50) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[14'h010] = 32'hDEADBEEF;

        // reset held with a pending CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
        repeat (3) @(negedge clock);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_ld_ack", 32'(ld_ack), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);

        // CPU read right after release
        exp_q.push_back(32'hDEADBEEF);
        reset = 1'b1;
        chk("rd_stall_c0", 32'(cpu_stall), 32'd1);
        @(negedge clock);
        chk("rd_addr_c1", 32'(mem_addr), 32'h010);
        chk("rd_we_c1", 32'(mem_we), 32'd0);
        chk("rd_stall_c1", 32'(cpu_stall), 32'd1);
        chk("rd_ack_c1", 32'(cpu_ack), 32'd0);
        @(negedge clock);
        chk("rd_ack_c2", 32'(cpu_ack), 32'd1);
        chk("rd_stall_c2", 32'(cpu_stall), 32'd0);
        chk("rd_data_c2", cpu_rdata, exp_q.pop_front());
        cpu_req = 1'b0;
        @(negedge clock);
        chk("rd_ack_c3", 32'(cpu_ack), 32'd0);
        chk("rd_data_hold", cpu_rdata, 32'hDEADBEEF);

        // loader write in boot mode, then CPU readback
        boot_mode = 1'b1;
        ld_req = 1'b1; ld_addr = 14'h3FF; ld_wdata = 32'h12345678;
        @(negedge clock);
        chk("ld_we_c1", 32'(mem_we), 32'd1);
        chk("ld_owner_c1", 32'(owner), 32'd1);
        chk("ld_addr_c1", 32'(mem_addr), 32'h3FF);
        @(negedge clock);
        chk("ld_ack_c2", 32'(ld_ack), 32'd1);
        chk("ld_no_cpu_ack", 32'(cpu_ack), 32'd0);
        ld_req = 1'b0;
        @(negedge clock);
        chk("ld_rdata_untouched", cpu_rdata, 32'hDEADBEEF);
        boot_mode = 1'b0;
        cpu_we = 1'b0; cpu_addr = 14'h3FF; cpu_req = 1'b1;
        exp_q.push_back(32'h12345678);
        wait_cpu_ack(n);
        chk("rb_latency", 32'(n), 32'd2);
        chk("rb_data", cpu_rdata, exp_q.pop_front());
        cpu_req = 1'b0;
        @(negedge clock);

        // boot lock keeps the CPU stalled
        boot_mode = 1'b1;
        cpu_addr = 14'h010; cpu_req = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("lock_ack", 32'(cpu_ack), 32'd0);
            chk("lock_stall", 32'(cpu_stall), 32'd1);
        end
        boot_mode = 1'b0;
        wait_cpu_ack(n);
        chk("lock_latency", 32'(n), 32'd2);
        chk("lock_data", cpu_rdata, exp_q.pop_front());
        cpu_req = 1'b0;
        @(negedge clock);

        // reset during ISSUE of a CPU write
        cpu_we = 1'b1; cpu_addr = 14'h020; cpu_wdata = 32'hAAAA5555; cpu_req = 1'b1;
        @(negedge clock);
        chk("mw_we_issue", 32'(mem_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mw_we_dropped", 32'(mem_we), 32'd0);
        chk("mw_addr_reset", 32'(mem_addr), 32'd0);
        @(negedge clock);
        chk("mw_no_ack", 32'(cpu_ack), 32'd0);
        chk("mw_mem_kept", mem[14'h020], 32'h0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cpu_addr = 14'h020; cpu_req = 1'b1;
        exp_q.push_back(32'h0);
        wait_cpu_ack(n);
        chk("mw_idle_latency", 32'(n), 32'd2);
        chk("mw_readback", cpu_rdata, exp_q.pop_front());
        cpu_req = 1'b0;
        @(negedge clock);

        // contention: loader wins MAX_HOLD times, then the CPU
        for (int r = 0; r < 2; r++) begin
            own_q.push_back(32'd1); own_q.push_back(32'd1);
            own_q.push_back(32'd1); own_q.push_back(32'd0);
        end
        cpu_we = 1'b0; cpu_addr = 14'h3FF;
        ld_addr = 14'h100; ld_wdata = 32'hCAFE0000;
        ld_req = 1'b1; cpu_req = 1'b1;
        got = 0; cyc = 0;
        while (got < 8 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (ld_ack || cpu_ack) begin
                chk("grant_order", cpu_ack ? 32'd0 : 32'd1, own_q.pop_front());
                if (cpu_ack) chk("contend_rdata", cpu_rdata, 32'h12345678);
                got++;
            end
        end
        chk("contend_count", 32'(got), 32'd8);
        ld_req = 1'b0; cpu_req = 1'b0;
        @(negedge clock);
        chk("contend_ld_mem", mem[14'h100], 32'hCAFE0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
